// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control unit: a three-process FSM that sequences fetch, decode,
// execute, memory and writeback steps, with a bounded wait on mem_ready that traps on timeout.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        retire,
  output logic        fault,
  output logic [3:0]  state
);

  // Immediate and ALU codes mirror the Ext_Imm* / ALU_* values of define.v.
  localparam logic [2:0] EXT_IMM_I = 3'd0, EXT_IMM_S = 3'd1, EXT_IMM_B = 3'd2,
                         EXT_IMM_U = 3'd3, EXT_IMM_J = 3'd4;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SHIFTL = 4'd2,
                         ALU_LESS_THAN_SIGNED = 4'd3, ALU_LESS_THAN = 4'd4, ALU_XOR = 4'd5,
                         ALU_SHIFTR = 4'd6, ALU_SHIFTR_ARITH = 4'd7, ALU_OR = 4'd8,
                         ALU_AND = 4'd9, ALU_NONE = 4'd15;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_RTYPE = 7'b0110011,
                         OP_ITYPE = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3, S_MEMWB = 4'd4,
    S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9,
    S_JAL = 4'd10, S_LUI = 4'd11, S_TRAP = 4'd15
  } state_e;

  localparam int              CW     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TMO    = CW'(MEM_TIMEOUT);
  localparam logic            TMO_EN = (MEM_TIMEOUT > 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic            timeout_s;
  logic            unused_s;

  assign opcode_s  = inst[6:0];
  assign funct3_s  = inst[14:12];
  assign timeout_s = TMO_EN && (wait_q == TMO);
  assign unused_s  = ^{inst[31], inst[29:15], inst[11:7]};
  assign state     = state_q;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic b30, input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SHIFTL;
      3'b010:  alu_dec = ALU_LESS_THAN_SIGNED;
      3'b011:  alu_dec = ALU_LESS_THAN;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = b30 ? ALU_SHIFTR_ARITH : ALU_SHIFTR;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  // State and wait-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; mem_ready beats a timeout landing in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (timeout_s) state_d = S_TRAP;
        else                state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode_s)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode_s == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)      state_d = S_MEMWB;
        else if (timeout_s) state_d = S_TRAP;
        else                state_d = S_MEMREAD;
      end
      S_MEMWRITE: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (timeout_s) state_d = S_TRAP;
        else                state_d = S_MEMWRITE;
      end
      S_MEMWB, S_ALUWB, S_BRANCH, S_LUI: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:           state_d = S_ALUWB;
      S_TRAP:                            state_d = S_TRAP;
      default:                           state_d = S_FETCH;
    endcase
  end

  // Wait counter: restarts on every state change, saturates at the timeout value
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_req && !mem_ready && TMO_EN && (wait_q != TMO)) begin
      wait_d = wait_q + CW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Output decode per state
  always_comb begin
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = EXT_IMM_I;
    ALUControl = ALU_ADD;
    retire     = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (rst) begin
          mem_req = 1'b0;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
          end else begin
            IRWrite   = 1'b0;
          end
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode_s == OP_JAL) ? EXT_IMM_J : EXT_IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode_s == OP_STORE) ? EXT_IMM_S : EXT_IMM_I;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = alu_dec(funct3_s, inst[30], 1'b1);
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3_s, inst[30], 1'b0);
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_XOR;
        retire     = 1'b1;
        case (funct3_s)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = ~Zero;
          default: PCWrite = 1'b0;
        endcase
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ImmSrc     = EXT_IMM_U;
        ResultSrc  = 2'b11;
        RegWrite   = 1'b1;
        ALUControl = ALU_NONE;
        retire     = 1'b1;
      end
      S_TRAP:  fault = 1'b1;
      default: fault = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a directed vector table, randomized instructions checked
// against an instruction-level trace model, and hand sequences for reset, stalls and timeout.
module tb_multicycle_controller;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SHL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4,
                         A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9,
                         A_NONE = 4'd15;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'd0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, retire, fault;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl, state;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .inst(inst), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .retire(retire), .fault(fault), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, adr, irw, pcw, rgw, mw;
    logic [1:0] sa, sb, rs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ret, flt;
  } outs_t;

  typedef struct { logic rdy; outs_t e; } cyc_t;

  typedef struct {
    logic [31:0] ins;
    logic        z, rdy;
    logic [3:0]  st;
    logic        rgw, pcw, mw, ret;
    logic [3:0]  alu;
  } vec_t;

  cyc_t q[$];
  vec_t tbl[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic outs_t actual();
    return {state, mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
            ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, retire, fault};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic outs_t base(input logic [3:0] st);
    outs_t o;
    o     = '0;
    o.st  = st;
    o.imm = IMM_I;
    o.alu = A_ADD;
    return o;
  endfunction

  function automatic void push(input logic r, input outs_t o);
    cyc_t c;
    c.rdy = r;
    c.e   = o;
    q.push_back(c);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic b30, input logic is_r);
    logic [3:0] lut [8];
    logic [3:0] r;
    lut = '{A_ADD, A_SHL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    r = lut[f3];
    if (f3 == 3'b000 && is_r && b30) r = A_SUB;
    if (f3 == 3'b101 && b30) r = A_SRA;
    return r;
  endfunction

  // Expected per-cycle trace of one instruction: fd fetch stalls, md memory stalls.
  function automatic void build(input logic [31:0] ins, input logic z, input int fd, input int md);
    outs_t o;
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    q.delete();
    for (int i = 0; i < fd; i++) begin
      o = base(4'd0); o.mreq = 1'b1; push(1'b0, o);
    end
    o = base(4'd0); o.mreq = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; o.sb = 2'b10; o.rs = 2'b10;
    push(1'b1, o);
    o = base(4'd1); o.sa = 2'b01; o.sb = 2'b01; o.imm = (op == OP_JAL) ? IMM_J : IMM_B;
    push(rnd_bit(), o);
    if (op == OP_LOAD || op == OP_STORE) begin
      o = base(4'd2); o.sa = 2'b10; o.sb = 2'b01; o.imm = (op == OP_STORE) ? IMM_S : IMM_I;
      push(rnd_bit(), o);
      o = base((op == OP_STORE) ? 4'd5 : 4'd3); o.mreq = 1'b1; o.adr = 1'b1;
      o.mw = (op == OP_STORE);
      for (int i = 0; i < md; i++) push(1'b0, o);
      o.ret = (op == OP_STORE);
      push(1'b1, o);
      if (op == OP_LOAD) begin
        o = base(4'd4); o.rgw = 1'b1; o.rs = 2'b01; o.ret = 1'b1; push(rnd_bit(), o);
      end
    end else if (op == OP_R || op == OP_I) begin
      o = base((op == OP_R) ? 4'd6 : 4'd7); o.sa = 2'b10; o.sb = (op == OP_R) ? 2'b00 : 2'b01;
      o.alu = alu_ref(f3, ins[30], op == OP_R);
      push(rnd_bit(), o);
      o = base(4'd8); o.rgw = 1'b1; o.ret = 1'b1; push(rnd_bit(), o);
    end else if (op == OP_BR) begin
      o = base(4'd9); o.sa = 2'b10; o.alu = A_XOR; o.ret = 1'b1;
      o.pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0);
      push(rnd_bit(), o);
    end else if (op == OP_JAL) begin
      o = base(4'd10); o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1; push(rnd_bit(), o);
      o = base(4'd8); o.rgw = 1'b1; o.ret = 1'b1; push(rnd_bit(), o);
    end else if (op == OP_LUI) begin
      o = base(4'd11); o.imm = IMM_U; o.rs = 2'b11; o.rgw = 1'b1; o.alu = A_NONE; o.ret = 1'b1;
      push(rnd_bit(), o);
    end
  endfunction

  task automatic run_seq(input string nm, input logic [31:0] ins, input logic z, input int n);
    for (int i = 0; i < q.size() && i < n; i++) begin
      @(negedge clk);
      inst = ins; Zero = z; mem_ready = q[i].rdy;
      #1;
      chk(nm, 32'(actual()), 32'(q[i].e));
    end
  endtask

  function automatic void addv(input logic [31:0] ins, input logic z, input logic rdy,
                               input logic [3:0] st, input logic rgw, input logic pcw,
                               input logic mw, input logic ret, input logic [3:0] alu);
    vec_t v;
    v.ins = ins; v.z = z; v.rdy = rdy; v.st = st;
    v.rgw = rgw; v.pcw = pcw; v.mw = mw; v.ret = ret; v.alu = alu;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] ins;
    logic [6:0]  ops [8];
    outs_t       o;
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI, OP_BAD};

    // ins, Zero, mem_ready -> state, RegWrite, PCWrite, MemWrite, retire, ALUControl
    addv(32'h0000007F, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, A_ADD);
    addv(32'h0000007F, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    addv(32'h002081B3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, A_ADD);
    addv(32'h002081B3, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    addv(32'h002081B3, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    addv(32'h002081B3, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, A_ADD);
    addv(32'h402081B3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, A_ADD);
    addv(32'h402081B3, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    addv(32'h402081B3, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, A_SUB);
    addv(32'h402081B3, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, A_ADD);
    addv(32'h00208063, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, A_ADD);
    addv(32'h00208063, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    addv(32'h00208063, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, A_XOR);
    addv(32'h00208063, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, A_ADD);
    addv(32'h00208063, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    addv(32'h00208063, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, A_XOR);
    addv(32'h00209063, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, A_ADD);
    addv(32'h00209063, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    addv(32'h00209063, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, A_XOR);
    addv(32'h00209063, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, A_ADD);
    addv(32'h00209063, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    addv(32'h00209063, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, A_XOR);

    // Reset held: FETCH values with mem_req low even though mem_ready is high.
    mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("reset_outputs", 32'(actual()), 32'(base(4'd0)));
    mem_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      inst = tbl[i].ins; Zero = tbl[i].z; mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("table_row%0d", i),
          {20'd0, state, RegWrite, PCWrite, MemWrite, retire, ALUControl},
          {20'd0, tbl[i].st, tbl[i].rgw, tbl[i].pcw, tbl[i].mw, tbl[i].ret, tbl[i].alu});
    end

    repeat (60) begin
      ins = $urandom();
      ins[6:0] = ops[$urandom_range(0, 7)];
      Zero = rnd_bit();
      build(ins, Zero, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      run_seq("random_instr", ins, Zero, 1000);
    end

    build(32'h0000A183, 1'b0, 0, 3);   run_seq("lw_delay3", 32'h0000A183, 1'b0, 1000);
    build(32'h0020A223, 1'b0, 2, 4);   run_seq("sw_delay4", 32'h0020A223, 1'b0, 1000);
    build(32'h0000A183, 1'b0, 15, 15); run_seq("lw_ready_at_limit", 32'h0000A183, 1'b0, 1000);

    // Asynchronous reset in the middle of a load's memory wait.
    build(32'h0000A183, 1'b0, 0, 10);
    run_seq("lw_before_reset", 32'h0000A183, 1'b0, 5);
    #3 rst = 1'b1;
    #1 chk("reset_mid_wait", 32'(actual()), 32'(base(4'd0)));
    @(posedge clk); #2;
    rst = 1'b0;
    build(32'h002081B3, 1'b0, 1, 0);   run_seq("add_after_reset", 32'h002081B3, 1'b0, 1000);

    // Fetch stalls forever: 16 FETCH cycles (15 counted waits), then TRAP.
    o = base(4'd0); o.mreq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); mem_ready = 1'b0; #1;
      chk($sformatf("timeout_wait%0d", i), 32'(actual()), 32'(o));
    end
    o = base(4'd15); o.flt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      chk($sformatf("trap_hold%0d", i), 32'(actual()), 32'(o));
    end
    mem_ready = 1'b0;
    #3 rst = 1'b1;
    #1 chk("reset_mid_trap", 32'(actual()), 32'(base(4'd0)));
    @(posedge clk); #2;
    rst = 1'b0;
    build(32'h123450B7, 1'b0, 0, 0);   run_seq("lui_after_trap", 32'h123450B7, 1'b0, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum number of cycles waiting for mem_ready; 0 disables the timeout.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port inst  in  32  instruction register contents; valid from DECODE onward.
REQ-005 SHALL have port Zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  in  1  memory completes the current access this cycle.
REQ-007 SHALL have port mem_req  out  1  memory access request.
REQ-008 SHALL have port AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 SHALL have ports IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  write enables.
REQ-010 SHALL have port ALUSrcA  out  2  ALU operand A: 00=PC, 01=OldPC, 10=rs1.
REQ-011 SHALL have port ALUSrcB  out  2  ALU operand B: 00=rs2, 01=imm, 10=constant 4.
REQ-012 SHALL have port ResultSrc  out  2  result select: 00=ALUOut, 01=MemData, 10=ALUResult, 11=imm.
REQ-013 SHALL have ports ImmSrc  out  3  and ALUControl  out  4, using the define.v Ext_Imm* and ALU_* encodings.
REQ-014 SHALL have ports retire  out  1, fault  out  1, and state  out  4 (debug state code).

Function
REQ-015 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, TRAP=15.
REQ-016 Default outputs in every state unless overridden: all enables 0, mem_req 0, AdrSrc 0, ALUSrcA/B 00, ResultSrc 00, ImmSrc Ext_ImmI, ALUControl ALU_ADD, retire 0.
REQ-017 FETCH behaviour:
- mem_req=1, AdrSrc=0.
- While mem_ready=0: stay in FETCH.
- On mem_ready=1, in the same cycle: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10; next state DECODE.
REQ-018 DECODE behaviour:
- ALUSrcA=01, ALUSrcB=01, ALU_ADD.
- ImmSrc=Ext_ImmJ for OPCODE_JAL, Ext_ImmB otherwise.
- Next state: LOAD/STORE->MEMADR, RTYPE->EXECR, ITYPE->EXECI, BRANCH->BRANCH, JAL->JAL, LUI->LUI.
- Any other opcode->FETCH with no writes and no retire.
REQ-019 MEMADR: ALUSrcA=10, ALUSrcB=01, ALU_ADD; ImmSrc=Ext_ImmS for STORE, Ext_ImmI for LOAD; next state MEMREAD for LOAD, MEMWRITE for STORE.
REQ-020 MEMREAD: mem_req=1, AdrSrc=1; wait until mem_ready, then go to MEMWB. MEMWB: RegWrite=1, ResultSrc=01, retire=1; next state FETCH.
REQ-021 MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 held until mem_ready; retire=1 in the mem_ready cycle; next state FETCH.
REQ-022 EXECR/EXECI: ALUSrcA=10; ALUSrcB=00 (R) or 01 (I); next state ALUWB. ALUWB: RegWrite=1, ResultSrc=00, retire=1; next state FETCH.
REQ-023 ALU decode by funct3 (inst[14:12]):
- 000: ADD; SUB only for R-type with inst[30]=1.
- 001: SHIFTL. 010: LESS_THAN_SIGNED. 011: LESS_THAN. 100: XOR.
- 101: SHIFTR; SHIFTR_ARITH when inst[30]=1.
- 110: OR. 111: AND.
- All other funct7 bits are ignored.
REQ-024 BRANCH:
- ALUSrcA=10, ALUSrcB=00, ALU_XOR, ResultSrc=00, retire=1.
- PCWrite=Zero for funct3 000, ~Zero for 001, 0 otherwise.
- Next state FETCH.
REQ-025 JAL: ALUSrcA=01, ALUSrcB=10, ALU_ADD, ResultSrc=00, PCWrite=1; next state ALUWB, which writes PC+4 to rd.
REQ-026 LUI: ImmSrc=Ext_ImmU, ResultSrc=11, RegWrite=1, ALUControl=ALU_NONE, retire=1; next state FETCH.
REQ-027 Wait counter:
- Cleared on entry to FETCH, MEMREAD and MEMWRITE.
- Increments each cycle with mem_req=1 and mem_ready=0.
- When MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT with mem_ready still 0: next state TRAP.
- mem_ready in the same cycle as the timeout wins (normal completion).
REQ-028 TRAP: fault=1, all enables and mem_req 0; the block stays in TRAP until rst.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock edge, force state=FETCH, wait counter=0, fault=0. This applies also in the middle of a memory wait.
REQ-030 While rst=1, outputs SHALL be the FETCH values with mem_req=0. The first cycle after release SHALL be FETCH with mem_req=1.

Verification
REQ-031 ADD x3,x1,x2, mem_ready=1 in FETCH -> states 0,1,6,8; ALUWB shows RegWrite=1, ALU_ADD, retire=1. SUB (inst[30]=1) -> ALU_SUB.
REQ-032 LW with mem_ready delayed 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with RegWrite=1, ResultSrc=01.
REQ-033 BEQ: Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> PCWrite=0. BNE inverts both.
REQ-034 SW -> MemWrite=1 and AdrSrc=1 held until mem_ready; RegWrite never asserted.
REQ-035 mem_ready stuck at 0 in FETCH with MEM_TIMEOUT=15 -> TRAP after 15 wait cycles, fault=1; rst pulse mid-TRAP -> FETCH, fault=0.
REQ-036 Opcode 7'b1111111 -> DECODE returns to FETCH; no enable asserted, retire=0.
